// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Shares the single-port boot ROM between the instruction-fetch master (m0,
//   read-only) and the debug/download master (m1, read/write). m1 has fixed
//   priority. A 4-bit burst counter caps consecutive m1 grants while m0 waits,
//   so m0 cannot starve. ROM read data is combinational, so it is captured on
//   the grant cycle and returned on the next cycle.
//
// Optional feature macro: ROM_ARB_WPROT_EN
//   When defined, m1 writes outside [WrBase, WrLimit) are still granted. They
//   are kept off the ROM and answered with m1_err_o. When undefined, every m1
//   write reaches the ROM and m1_err_o is always 0.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   m0_req_i/addr_i          fetch request, byte address
//   m0_gnt_o                 fetch granted this cycle (combinational)
//   m0_rvalid_o/rdata_o      fetch response, one cycle after grant
//   m1_req_i/we_i/addr_i/wdata_i  debug request
//   m1_gnt_o                 debug granted this cycle (combinational)
//   m1_rvalid_o/rdata_o/err_o     debug response (rdata is 0 for writes)
//   rom_we_o/addr_o/wdata_o  drive to the ROM macro
//   rom_rdata_i              combinational read data from the ROM
module rom_arbiter #(
    parameter int unsigned MaxBurst = 4,
    parameter logic [31:0] WrBase   = 32'h0000_0000,
    parameter logic [31:0] WrLimit  = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        rom_we_o,
    output logic [31:0] rom_addr_o,
    output logic [31:0] rom_wdata_o,
    input  logic [31:0] rom_rdata_i
);

    localparam logic [3:0] MaxCnt = 4'(MaxBurst);

    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic        m0_rvalid_q, m0_rvalid_d;
    logic [31:0] m0_rdata_q,  m0_rdata_d;
    logic        m1_rvalid_q, m1_rvalid_d;
    logic [31:0] m1_rdata_q,  m1_rdata_d;
    logic        m1_err_q,    m1_err_d;

    logic m1_win;
    logic m0_gnt;
    logic m1_gnt;
    logic in_range;
    logic wr_ok;

    // One unsigned compare covers both bounds: addresses below WrBase wrap
    // to large offsets and fall outside the window as well.
    assign in_range = (m1_addr_i - WrBase) < (WrLimit - WrBase);

`ifdef ROM_ARB_WPROT_EN
    assign wr_ok = in_range;
`else
    // The range decode is kept so both builds share one datapath. The OR
    // makes it a don't-care, so every write is allowed.
    assign wr_ok = 1'b1 | in_range;
`endif

    // m1 wins every contended cycle until m0 has waited MaxBurst grants.
    // Grants are masked during reset so nothing reaches the ROM.
    always_comb begin
        m1_win = m1_req_i && !(m0_req_i && (burst_cnt_q == MaxCnt));
        m1_gnt = rst_ni && m1_win;
        m0_gnt = rst_ni && m0_req_i && !m1_win;
    end

    assign m0_gnt_o    = m0_gnt;
    assign m1_gnt_o    = m1_gnt;
    assign rom_addr_o  = m1_gnt ? m1_addr_i : m0_addr_i;
    assign rom_we_o    = m1_gnt && m1_we_i && wr_ok;
    assign rom_wdata_o = m1_wdata_i;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!m0_req_i || m0_gnt) begin
            burst_cnt_d = 4'd0;
        end else if (m1_gnt && (burst_cnt_q != MaxCnt)) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end
    end

    // Responses: rdata holds its last value across idle cycles.
    always_comb begin
        m0_rvalid_d = m0_gnt;
        m0_rdata_d  = m0_gnt ? rom_rdata_i : m0_rdata_q;
        m1_rvalid_d = m1_gnt;
        m1_rdata_d  = m1_rdata_q;
        if (m1_gnt) begin
            m1_rdata_d = m1_we_i ? 32'd0 : rom_rdata_i;
        end
        m1_err_d    = m1_gnt && m1_we_i && !wr_ok;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            burst_cnt_q <= 4'd0;
            m0_rvalid_q <= 1'b0;
            m0_rdata_q  <= 32'd0;
            m1_rvalid_q <= 1'b0;
            m1_rdata_q  <= 32'd0;
            m1_err_q    <= 1'b0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rvalid_q <= m1_rvalid_d;
            m1_rdata_q  <= m1_rdata_d;
            m1_err_q    <= m1_err_d;
        end
    end

    assign m0_rvalid_o = m0_rvalid_q;
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rvalid_o = m1_rvalid_q;
    assign m1_rdata_o  = m1_rdata_q;
    assign m1_err_o    = m1_err_q;

endmodule
